// File: rtl/abc_pattern_gen_pkg.sv
// Shared types and helpers for the A/B/C stimulus sequencer.
package abc_pattern_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_HOLD_CYCLES = 4;
  localparam logic [2:0]  LAST_PATTERN_IDX    = 3'd7;

  function automatic logic [2:0] gray3(input logic [2:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray order visits every code exactly once, so res_x stays indexed by idx.
  function automatic logic [2:0] patternCode(input logic grayMode, input logic [2:0] idx);
    return grayMode ? gray3(idx) : idx;
  endfunction

endpackage

// File: rtl/abc_hold_timer.sv
// Per-pattern hold counter; o_tc marks the last cycle a pattern is driven.
module abc_hold_timer #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned HOLD_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [HOLD_W-1:0] LAST_COUNT = HOLD_W'(HOLD_CYCLES - 1);

  logic [HOLD_W-1:0] r_count;
  logic              w_atLast;

  assign w_atLast = (r_count == LAST_COUNT);
  assign o_tc     = i_enable && !i_clear && w_atLast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      if (w_atLast) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/abc_pattern_gen.sv
// Steps A/B/C through all eight codes (binary or Gray), holding each for
// HOLD_CYCLES clocks, and captures the gate's D/E outputs once per pattern.
module abc_pattern_gen
  import abc_pattern_gen_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int unsigned HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic       loop,
  input  logic       D,
  input  logic       E,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic [2:0] pat_idx,
  output logic       busy,
  output logic       done,
  output logic [7:0] res_d,
  output logic [7:0] res_e,
  output logic       res_valid
);

  state_t     r_state;
  logic       r_mode;
  logic [2:0] r_idx;
  logic [2:0] r_code;
  logic       r_busy;
  logic       r_done;
  logic       r_resValid;
  logic [7:0] r_resD;
  logic [7:0] r_resE;

  logic       w_holdTc;
  logic       w_timerClear;
  logic       w_timerEnable;
  logic       w_lastPattern;
  logic [2:0] w_nextIdx;

  // Timer only runs in RUN so every pass starts from a fresh hold count.
  assign w_timerEnable = (r_state == RUN);
  assign w_timerClear  = (r_state != RUN) || stop;
  assign w_lastPattern = (r_idx == LAST_PATTERN_IDX);
  assign w_nextIdx     = r_idx + 3'd1;

  abc_hold_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .HOLD_W      (HOLD_W)
  ) u_holdTimer (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_timerClear),
    .i_enable (w_timerEnable),
    .o_tc     (w_holdTc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_mode     <= 1'b0;
      r_idx      <= 3'd0;
      r_code     <= 3'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_resValid <= 1'b0;
      r_resD     <= 8'h00;
      r_resE     <= 8'h00;
    end else if (stop) begin
      // Abort from RUN keeps the partial results but marks them invalid.
      r_state <= IDLE;
      r_idx   <= 3'd0;
      r_code  <= 3'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      if (r_state == RUN) begin
        r_resValid <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_code <= 3'd0;
          r_busy <= 1'b0;
          r_done <= 1'b0;
          if (start) begin
            r_state    <= RUN;
            r_mode     <= mode;
            r_idx      <= 3'd0;
            r_code     <= patternCode(mode, 3'd0);
            r_busy     <= 1'b1;
            r_resValid <= 1'b0;
            r_resD     <= 8'h00;
            r_resE     <= 8'h00;
          end
        end

        RUN: begin
          if (w_holdTc) begin
            r_resD[r_idx] <= D;
            r_resE[r_idx] <= E;
            if (w_lastPattern) begin
              r_resValid <= 1'b1;
              r_idx      <= 3'd0;
              if (loop) begin
                r_code <= patternCode(r_mode, 3'd0);
              end else begin
                r_state <= DONE;
                r_code  <= 3'd0;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_idx  <= w_nextIdx;
              r_code <= patternCode(r_mode, w_nextIdx);
            end
          end
        end

        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state <= IDLE;
          r_code  <= 3'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign A         = r_code[0];
  assign B         = r_code[1];
  assign C         = r_code[2];
  assign pat_idx   = r_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign res_d     = r_resD;
  assign res_e     = r_resE;
  assign res_valid = r_resValid;

endmodule

// File: tb/tb_abc_pattern_gen.sv
// Scoreboard bench for abc_pattern_gen driving an OR/AND gate model on D/E.
module tb_abc_pattern_gen;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       mode;
  logic       loop;
  logic       D;
  logic       E;
  logic       A;
  logic       B;
  logic       C;
  logic [2:0] pat_idx;
  logic       busy;
  logic       done;
  logic [7:0] res_d;
  logic [7:0] res_e;
  logic       res_valid;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [2:0] code;
    logic [2:0] idx;
  } exp_t;

  exp_t       expQ[$];
  exp_t       monExp;
  int         total = 0;
  int         bad   = 0;
  logic [2:0] binSeq  [8];
  logic [2:0] graySeq [8];

  // Gate under test: D = A|B|C, E = A&B&C.
  assign D = A | B | C;
  assign E = A & B & C;

  always #5 clk = ~clk;

  abc_pattern_gen #(
    .HOLD_CYCLES (H),
    .HOLD_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .mode      (mode),
    .loop      (loop),
    .D         (D),
    .E         (E),
    .A         (A),
    .B         (B),
    .C         (C),
    .pat_idx   (pat_idx),
    .busy      (busy),
    .done      (done),
    .res_d     (res_d),
    .res_e     (res_e),
    .res_valid (res_valid)
  );

  task automatic applyStimulus(input logic s, input logic p, input logic m, input logic l);
    start = s;
    stop  = p;
    mode  = m;
    loop  = l;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One expected entry per cycle the DUT shows busy.
  task automatic pushPartial(input logic grayOrder, input int nCycles);
    exp_t e;
    for (int c = 0; c < nCycles; c++) begin
      int i;
      i      = (c / H) % 8;
      e.busy = 1'b1;
      e.done = 1'b0;
      e.idx  = 3'(i);
      e.code = grayOrder ? graySeq[i] : binSeq[i];
      expQ.push_back(e);
    end
  endtask

  task automatic pushDone();
    exp_t e;
    e.busy = 1'b0;
    e.done = 1'b1;
    e.code = 3'd0;
    e.idx  = 3'd0;
    expQ.push_back(e);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, expQ.size(), 0);
    expQ.delete();
  endtask

  always @(negedge clk) begin
    if (!rst && (busy || done)) begin
      total++;
      if (expQ.size() == 0) begin
        bad++;
        $display("[TB] FAIL unexpected_output: got busy=%0b done=%0b abc=%03b, expected no activity",
                 busy, done, {C, B, A});
      end else begin
        monExp = expQ.pop_front();
        if (busy !== monExp.busy || done !== monExp.done || {C, B, A} !== monExp.code ||
            (monExp.busy && pat_idx !== monExp.idx)) begin
          bad++;
          $display("[TB] FAIL sequence: got busy=%0b done=%0b abc=%03b idx=%0d, expected busy=%0b done=%0b abc=%03b idx=%0d",
                   busy, done, {C, B, A}, pat_idx, monExp.busy, monExp.done, monExp.code, monExp.idx);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    binSeq  = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111};
    graySeq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0);

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_abc", {C, B, A}, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_res_d", res_d, 0);
    checkOutput("reset_pat_idx", pat_idx, 0);
    rst = 1'b0;

    // Binary pass, start re-asserted mid-RUN
    @(negedge clk);
    applyStimulus(1, 0, 0, 0);
    pushPartial(1'b0, 8 * H);
    pushDone();
    @(negedge clk);
    start = 1'b0;
    checkOutput("bin_start_latency_busy", busy, 1);
    repeat (5) @(negedge clk);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    repeat (8 * H - 8) @(negedge clk);
    checkOutput("bin_done_pulse", done, 1);
    checkOutput("bin_busy_low", busy, 0);
    checkOutput("bin_res_valid", res_valid, 1);
    checkOutput("bin_res_d", res_d, 8'hFE);
    checkOutput("bin_res_e", res_e, 8'h80);
    @(negedge clk);
    checkOutput("bin_done_one_cycle", done, 0);
    waitDrain("bin_drain");

    // start and stop together in IDLE: stop wins
    applyStimulus(1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("start_stop_idle_busy", busy, 0);
    end
    applyStimulus(0, 0, 0, 0);
    @(negedge clk);

    // Gray pass with mode flipped mid-pass
    applyStimulus(1, 0, 1, 0);
    pushPartial(1'b1, 8 * H);
    pushDone();
    @(negedge clk);
    start = 1'b0;
    checkOutput("gray_res_valid_cleared", res_valid, 0);
    checkOutput("gray_res_d_cleared", res_d, 0);
    mode = 1'b0;
    repeat (8 * H) @(negedge clk);
    checkOutput("gray_done_pulse", done, 1);
    checkOutput("gray_res_d", res_d, 8'hFE);
    checkOutput("gray_res_e", res_e, 8'h20);
    checkOutput("gray_res_valid", res_valid, 1);
    waitDrain("gray_drain");
    @(negedge clk);

    // Abort while idx=5
    applyStimulus(1, 0, 0, 0);
    pushPartial(1'b0, 5 * H + 2);
    @(negedge clk);
    start = 1'b0;
    repeat (5 * H + 1) @(negedge clk);
    checkOutput("abort_at_idx5", pat_idx, 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checkOutput("abort_abc", {C, B, A}, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_res_valid", res_valid, 0);
    checkOutput("abort_res_d", res_d, 8'h1E);
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", done, 0);
    waitDrain("abort_drain");

    // Loop: two passes, loop dropped during the second
    applyStimulus(1, 0, 0, 1);
    pushPartial(1'b0, 8 * H);
    pushPartial(1'b0, 8 * H);
    pushDone();
    @(negedge clk);
    start = 1'b0;
    repeat (8 * H) @(negedge clk);
    checkOutput("loop_wrap_busy", busy, 1);
    checkOutput("loop_wrap_abc", {C, B, A}, 0);
    checkOutput("loop_wrap_idx", pat_idx, 0);
    checkOutput("loop_wrap_no_done", done, 0);
    checkOutput("loop_wrap_res_valid", res_valid, 1);
    repeat (4) @(negedge clk);
    loop = 1'b0;
    repeat (8 * H - 4) @(negedge clk);
    checkOutput("loop_final_done", done, 1);
    waitDrain("loop_drain");
    @(negedge clk);

    // Asynchronous reset during pattern 3
    applyStimulus(1, 0, 0, 0);
    pushPartial(1'b0, 3 * H + 2);
    @(negedge clk);
    start = 1'b0;
    repeat (3 * H + 1) @(negedge clk);
    checkOutput("rst_at_idx3", pat_idx, 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_abc", {C, B, A}, 0);
    checkOutput("rst_async_busy", busy, 0);
    checkOutput("rst_async_idx", pat_idx, 0);
    checkOutput("rst_async_res_d", res_d, 0);
    checkOutput("rst_async_res_valid", res_valid, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    waitDrain("rst_drain");
    @(negedge clk);

    // Fresh pass after reset
    applyStimulus(1, 0, 0, 0);
    pushPartial(1'b0, 8 * H);
    pushDone();
    @(negedge clk);
    start = 1'b0;
    checkOutput("post_rst_busy", busy, 1);
    checkOutput("post_rst_idx", pat_idx, 0);
    repeat (8 * H) @(negedge clk);
    checkOutput("post_rst_done", done, 1);
    checkOutput("post_rst_res_d", res_d, 8'hFE);
    waitDrain("post_rst_drain");

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
